cache_mem_model: RTL and testbench
==================================

Name: cache_mem_model

Overview:
- Synthesizable memory-side responder for the cache refill/writeback interface (rd_req/ret_* and wr_req/wr_rdy).
- The cache is the initiator; this block accepts line reads and returns 4-beat bursts, and accepts 128-bit line writebacks.
- Holds a line-wide backing store with programmable response latency.
- Replaces ad-hoc per-bench responders in cache unit benches and SoC simulation.

Parameters:
- LINE_BITS, 8, log2 of backing-store line count. Default is 256 lines x 16 B = 4 KB. Line index = addr[LINE_BITS+3:4].
- RD_LATENCY, 2, idle cycles between read accept and first ret_valid beat. Legal range 0..15.
- WR_LATENCY, 1, cycles between write accept and commit to store. Legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- rd_req  in  1  cache requests a line read
- rd_addr  in  32  read address; bits [3:0] ignored
- rd_rdy  out  1  responder can accept a read this cycle
- ret_valid  out  1  read return beat valid
- ret_last  out  1  final (4th) beat of the burst
- ret_data  out  32  read return word
- wr_req  in  1  cache requests a line write
- wr_addr  in  32  write address; bits [3:0] ignored
- wr_data  in  128  line data; word k at bits [32k+31:32k]
- wr_rdy  out  1  responder can accept a write this cycle
- rd_count  out  16  accepted reads since reset, wraps 0xFFFF->0
- wr_count  out  16  accepted writes since reset, wraps 0xFFFF->0

Behaviour:
- Address mapping:
  - Line index = addr[LINE_BITS+3:4].
  - Address bits above the index are ignored, so lines alias modulo 2^LINE_BITS.
  - addr[3:0] is ignored on both ports.
- Reset (resetn=0 at clk edge):
  - Read FSM goes to R_IDLE, write FSM to W_IDLE.
  - ret_valid=0, ret_last=0, ret_data=0, rd_count=0, wr_count=0.
  - rd_rdy=1 and wr_rdy=1 from the first cycle after reset.
  - Backing-store contents are not cleared.
  - A write accepted but not yet committed is dropped.
  - A burst in progress is abandoned with no further beats.
- Read FSM: R_IDLE -> R_WAIT -> R_BURST -> R_IDLE.
  - rd_rdy = (read state R_IDLE) && (write state W_IDLE). Reads are never accepted while a write is pending.
  - Accept when rd_req && rd_rdy:
    - snapshot the whole 128-bit line into a burst buffer;
    - rd_count increments;
    - latency counter loads RD_LATENCY.
  - R_WAIT is held for RD_LATENCY cycles. With RD_LATENCY=0, R_WAIT is skipped and the first beat is on the cycle after accept.
  - R_BURST runs exactly 4 consecutive cycles with ret_valid=1:
    - beat b drives buffer word b, b=0..3;
    - ret_last=1 on beat 3 only.
  - There is no backpressure; the cache must sink every beat.
  - After beat 3 the FSM returns to R_IDLE, so rd_rdy can be 1 on the following cycle.
  - Latency from accept edge to first beat is RD_LATENCY+1 cycles.
  - Outside R_BURST: ret_valid=0, ret_last=0, ret_data=0.
- Write FSM: W_IDLE -> W_BUSY -> W_IDLE.
  - wr_rdy = (write state W_IDLE). Writes may be accepted while a read is in R_WAIT or R_BURST.
  - Accept when wr_req && wr_rdy:
    - latch line index and wr_data;
    - wr_count increments;
    - latency counter loads WR_LATENCY.
  - Commit on the WR_LATENCY-th cycle after accept: all 128 bits are written in one cycle. The FSM returns to W_IDLE on the same edge.
  - No byte strobes; writes are full-line only.
- Ordering and simultaneous events:
  - rd_req and wr_req asserted in the same cycle with both FSMs idle: both are accepted on that edge.
  - In that case the read snapshot takes the pre-write contents. Read-after-write ordering is the initiator's responsibility, which matches a cache issuing miss-read before dirty writeback.
  - A write committing during a burst to the same line does not alter the in-flight burst, because it is served from the snapshot.
  - A read request while a write is pending stalls (rd_rdy=0) until the commit cycle has passed. The read is therefore always ordered after that write.
  - Request signals may stay high after acceptance. A new accept occurs only when the ready signal is high again.
- Counters saturate never; they wrap at 16 bits.

Test Plan:
- Write line 0x0001_2340, data {0x44444444,0x33333333,0x22222222,0x11111111}, then read 0x0001_2348 with RD_LATENCY=2 -> first ret_valid 3 cycles after read accept; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444; ret_last only on beat 4; rd_count=1, wr_count=1.
- RD_LATENCY=0, read accepted at cycle N -> ret_valid at N+1..N+4; rd_rdy=0 at N+1..N+4 and 1 at N+5; back-to-back second read bursts with no gap beyond one idle cycle.
- Write pending (wr_rdy=0), then rd_req to the same line -> rd_rdy held 0 until after commit; read returns the newly written data.
- rd_req and wr_req in the same cycle, same line, old data 0xAAAA_xxxx, new data 0xBBBB_xxxx -> burst returns old data; a subsequent read returns new data.
- Aliasing with LINE_BITS=8 -> a write to 0x0000_1000 is read back from 0x0000_0000; a write to 0xFFFF_F010 is read back from 0x0000_0010.
- Assert resetn=0 during burst beat 2 and during W_BUSY -> next cycle ret_valid=0, counters 0, rd_rdy=wr_rdy=1; the dropped write's line retains its prior data.

Source files
------------

// File: rtl/cache_mem_model.sv
// Memory-side responder for the cache refill/writeback interface.
// Returns 4-beat read bursts from a line-wide store and commits full-line writebacks.
module cache_mem_model #(
  parameter int unsigned LINE_BITS  = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int unsigned LINES  = 1 << LINE_BITS;
  localparam int unsigned IDX_HI = LINE_BITS + 3;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
  typedef enum logic       {W_IDLE, W_BUSY}          wr_state_t;

  rd_state_t              rd_state, rd_state_n;
  wr_state_t              wr_state, wr_state_n;
  logic [3:0]             rd_cnt, rd_cnt_n;
  logic [3:0]             wr_cnt, wr_cnt_n;
  logic [1:0]             beat, beat_n;
  logic [15:0]            rd_count_n, wr_count_n;
  logic                   ret_valid_n, ret_last_n;
  logic [31:0]            ret_data_n;
  logic                   rd_rdy_n, wr_rdy_n;
  logic                   rd_acc, wr_acc, commit;
  logic [127:0]           rd_buf, rd_buf_n;
  logic [LINE_BITS-1:0]   wr_idx;
  logic [127:0]           wr_line;
  logic [127:0]           mem [LINES];
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{rd_addr[31:IDX_HI+1], rd_addr[3:0],
                              wr_addr[31:IDX_HI+1], wr_addr[3:0]};

  // Next-state and next-output logic for both FSMs
  always_comb begin
    rd_state_n = rd_state;
    wr_state_n = wr_state;
    rd_cnt_n   = rd_cnt;
    wr_cnt_n   = wr_cnt;
    beat_n     = beat;
    rd_count_n = rd_count;
    wr_count_n = wr_count;
    commit     = 1'b0;
    rd_acc     = rd_req && rd_rdy;
    wr_acc     = wr_req && wr_rdy;
    rd_buf_n   = rd_buf;

    case (rd_state)
      R_IDLE: begin
        if (rd_acc) begin
          rd_buf_n   = mem[rd_addr[IDX_HI:4]];
          rd_count_n = rd_count + 16'd1;
          rd_cnt_n   = 4'(RD_LATENCY);
          beat_n     = 2'd0;
          rd_state_n = (RD_LATENCY == 0) ? R_BURST : R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt <= 4'd1) begin
          rd_cnt_n   = 4'd0;
          rd_state_n = R_BURST;
        end else begin
          rd_cnt_n = rd_cnt - 4'd1;
        end
      end
      R_BURST: begin
        beat_n = beat + 2'd1;
        if (beat == 2'd3) rd_state_n = R_IDLE;
      end
      default: rd_state_n = R_IDLE;
    endcase

    case (wr_state)
      W_IDLE: begin
        if (wr_acc) begin
          wr_count_n = wr_count + 16'd1;
          wr_cnt_n   = 4'(WR_LATENCY);
          wr_state_n = W_BUSY;
        end
      end
      W_BUSY: begin
        if (wr_cnt <= 4'd1) begin
          commit     = 1'b1;
          wr_cnt_n   = 4'd0;
          wr_state_n = W_IDLE;
        end else begin
          wr_cnt_n = wr_cnt - 4'd1;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase

    ret_valid_n = (rd_state_n == R_BURST);
    ret_last_n  = ret_valid_n && (beat_n == 2'd3);
    ret_data_n  = ret_valid_n ? rd_buf_n[{beat_n, 5'd0} +: 32] : 32'd0;
    rd_rdy_n    = (rd_state_n == R_IDLE) && (wr_state_n == W_IDLE);
    wr_rdy_n    = (wr_state_n == W_IDLE);
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state  <= R_IDLE;
      wr_state  <= W_IDLE;
      rd_cnt    <= 4'd0;
      wr_cnt    <= 4'd0;
      beat      <= 2'd0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= 32'd0;
      rd_rdy    <= 1'b1;
      wr_rdy    <= 1'b1;
    end else begin
      rd_state  <= rd_state_n;
      wr_state  <= wr_state_n;
      rd_cnt    <= rd_cnt_n;
      wr_cnt    <= wr_cnt_n;
      beat      <= beat_n;
      rd_count  <= rd_count_n;
      wr_count  <= wr_count_n;
      ret_valid <= ret_valid_n;
      ret_last  <= ret_last_n;
      ret_data  <= ret_data_n;
      rd_rdy    <= rd_rdy_n;
      wr_rdy    <= wr_rdy_n;
    end
  end

  // Datapath: burst snapshot, pending write, backing store (never cleared)
  always_ff @(posedge clk) begin
    rd_buf <= rd_buf_n;
    if (wr_acc) begin
      wr_idx  <= wr_addr[IDX_HI:4];
      wr_line <= wr_data;
    end
    if (commit && resetn) mem[wr_idx] <= wr_line;
  end

endmodule

// File: tb/tb_cache_mem_model.sv
// Directed bench for cache_mem_model: burst timing, write ordering, aliasing and reset.
module tb_cache_mem_model;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req, wr_req;
  logic [31:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;
  logic         rd_rdy, ret_valid, ret_last, wr_rdy;
  logic [31:0]  ret_data;
  logic [15:0]  rd_count, wr_count;

  logic         rd_req0, wr_req0;
  logic [31:0]  rd_addr0, wr_addr0;
  logic [127:0] wr_data0;
  logic         rd_rdy0, ret_valid0, ret_last0, wr_rdy0;
  logic [31:0]  ret_data0;
  logic [15:0]  rd_count0, wr_count0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_mem_model #(.LINE_BITS(8), .RD_LATENCY(2), .WR_LATENCY(1)) u_dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  cache_mem_model #(.LINE_BITS(8), .RD_LATENCY(0), .WR_LATENCY(1)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_rdy(rd_rdy0),
    .ret_valid(ret_valid0), .ret_last(ret_last0), .ret_data(ret_data0),
    .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_rdy(wr_rdy0),
    .rd_count(rd_count0), .wr_count(wr_count0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the W_BUSY cycle following the accept edge
  task automatic do_write(input logic [31:0] a, input logic [127:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] a);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
  endtask

  // Starts on cycle 1 after accept; lat=0 means no beat appeared
  task automatic capture_burst(output logic [127:0] line, output int lat, output logic [3:0] lastm);
    line = '0; lastm = '0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (ret_valid === 1'b1) begin lat = c; break; end
      tick();
    end
    if (lat != 0) begin
      for (int b = 0; b < 4; b++) begin
        line[b*32 +: 32] = ret_data;
        lastm[b] = ret_last;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL reset_ret_valid: got %b want 0", ret_valid); end
    checks++; if (ret_data !== 32'd0) begin errors++; $display("FAIL reset_ret_data: got %h want 0", ret_data); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    checks++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b%b want 11", rd_rdy, wr_rdy); end
    checks++; if (rd_rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rd_rdy0: got %b want 1", rd_rdy0); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [127:0] line;
    int lat;
    logic [3:0] lastm;
    do_write(32'h0001_2340, 128'h44444444_33333333_22222222_11111111);
    checks++; if (wr_rdy !== 1'b0 || rd_rdy !== 1'b0) begin errors++; $display("FAIL wr_busy_rdy: got %b%b want 00", wr_rdy, rd_rdy); end
    tick();
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL wr_commit_rdy: got %b want 1", wr_rdy); end
    issue_read(32'h0001_2348);
    capture_burst(line, lat, lastm);
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
    checks++; if (line !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL rd_data: got %h", line); end
    checks++; if (lastm !== 4'b1000) begin errors++; $display("FAIL rd_last: got %b want 1000", lastm); end
    checks++; if (rd_rdy !== 1'b1 || ret_valid !== 1'b0) begin errors++; $display("FAIL post_burst: rdy %b valid %b want 1 0", rd_rdy, ret_valid); end
    checks++; if (rd_count !== 16'd1 || wr_count !== 16'd1) begin errors++; $display("FAIL counts: rd %0d wr %0d want 1 1", rd_count, wr_count); end
  endtask

  task automatic test_lat0_back_to_back();
    logic [127:0] d;
    d = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    wr_req0 = 1'b1; wr_addr0 = 32'h0000_0100; wr_data0 = d;
    tick();
    wr_req0 = 1'b0;
    tick();
    rd_req0 = 1'b1; rd_addr0 = 32'h0000_0104;
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++; if (ret_valid0 !== 1'b1 || rd_rdy0 !== 1'b0) begin errors++; $display("FAIL lat0_beat%0d_ctl: valid %b rdy %b want 1 0", b, ret_valid0, rd_rdy0); end
      checks++; if (ret_data0 !== d[b*32 +: 32] || ret_last0 !== (b == 3)) begin errors++; $display("FAIL lat0_beat%0d: data %h last %b want %h %b", b, ret_data0, ret_last0, d[b*32 +: 32], (b == 3)); end
      tick();
    end
    checks++; if (rd_rdy0 !== 1'b1 || ret_valid0 !== 1'b0) begin errors++; $display("FAIL lat0_idle: rdy %b valid %b want 1 0", rd_rdy0, ret_valid0); end
    tick();
    rd_req0 = 1'b0;
    checks++; if (ret_valid0 !== 1'b1 || ret_data0 !== d[31:0]) begin errors++; $display("FAIL lat0_second: valid %b data %h want 1 %h", ret_valid0, ret_data0, d[31:0]); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (rd_count0 !== 16'd2 || ret_valid0 !== 1'b0) begin errors++; $display("FAIL lat0_count: %0d valid %b want 2 0", rd_count0, ret_valid0); end
  endtask

  task automatic test_write_stall();
    logic [127:0] line;
    int lat;
    logic [3:0] lastm;
    do_write(32'h0000_0500, 128'h55555555_66666666_77777777_88888888);
    rd_req = 1'b1; rd_addr = 32'h0000_0500;
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL stall_rd_rdy: got %b want 0", rd_rdy); end
    tick();
    checks++; if (rd_rdy !== 1'b1 || rd_count !== 16'd1) begin errors++; $display("FAIL stall_release: rdy %b count %0d want 1 1", rd_rdy, rd_count); end
    tick();
    rd_req = 1'b0;
    checks++; if (rd_count !== 16'd2) begin errors++; $display("FAIL stall_accept: count %0d want 2", rd_count); end
    capture_burst(line, lat, lastm);
    checks++; if (line !== 128'h55555555_66666666_77777777_88888888 || lat != 3) begin errors++; $display("FAIL stall_data: got %h lat %0d", line, lat); end
  endtask

  task automatic test_simultaneous();
    logic [127:0] line;
    int lat;
    logic [3:0] lastm;
    do_write(32'h0000_0600, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
    tick();
    rd_req = 1'b1; rd_addr = 32'h0000_0600;
    wr_req = 1'b1; wr_addr = 32'h0000_0600; wr_data = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    checks++; if (rd_count !== 16'd3 || wr_count !== 16'd4) begin errors++; $display("FAIL simul_counts: rd %0d wr %0d want 3 4", rd_count, wr_count); end
    capture_burst(line, lat, lastm);
    checks++; if (line !== 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000) begin errors++; $display("FAIL simul_old: got %h", line); end
    issue_read(32'h0000_0600);
    capture_burst(line, lat, lastm);
    checks++; if (line !== 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000) begin errors++; $display("FAIL simul_new: got %h", line); end
  endtask

  task automatic test_alias();
    logic [127:0] line;
    int lat;
    logic [3:0] lastm;
    do_write(32'h0000_1000, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C);
    tick();
    issue_read(32'h0000_0000);
    capture_burst(line, lat, lastm);
    checks++; if (line !== 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C) begin errors++; $display("FAIL alias_1000: got %h", line); end
    do_write(32'hFFFF_F010, 128'h12345678_9ABCDEF0_CAFEBABE_DEADBEEF);
    tick();
    issue_read(32'h0000_0010);
    capture_burst(line, lat, lastm);
    checks++; if (line !== 128'h12345678_9ABCDEF0_CAFEBABE_DEADBEEF) begin errors++; $display("FAIL alias_f010: got %h", line); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] line;
    int lat;
    logic [3:0] lastm;
    do_write(32'h0000_0700, 128'h70000003_70000002_70000001_70000000);
    tick();
    issue_read(32'h0000_0700);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (ret_valid !== 1'b1 || ret_data !== 32'h70000002) begin errors++; $display("FAIL mid_beat2: valid %b data %h want 1 70000002", ret_valid, ret_data); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (ret_valid !== 1'b0 || ret_last !== 1'b0 || ret_data !== 32'd0) begin errors++; $display("FAIL mid_burst_ret: valid %b last %b data %h want 0 0 0", ret_valid, ret_last, ret_data); end
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0 || rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin errors++; $display("FAIL mid_burst_state: rd %0d wr %0d rdy %b%b want 0 0 11", rd_count, wr_count, rd_rdy, wr_rdy); end
    tick();
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL mid_burst_abandon: valid %b want 0", ret_valid); end
    do_write(32'h0000_0700, 128'h99999999_99999999_99999999_99999999);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b1 || wr_count !== 16'd0) begin errors++; $display("FAIL mid_write_state: wr_rdy %b rd_rdy %b wr_count %0d want 1 1 0", wr_rdy, rd_rdy, wr_count); end
    tick();
    issue_read(32'h0000_0700);
    capture_burst(line, lat, lastm);
    checks++; if (line !== 128'h70000003_70000002_70000001_70000000) begin errors++; $display("FAIL mid_write_dropped: got %h", line); end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL mid_rd_count: got %0d want 1", rd_count); end
  endtask

  initial begin
    resetn = 1'b0;
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req0 = 1'b0; rd_addr0 = '0; wr_req0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    test_reset();
    test_write_read();
    test_lat0_back_to_back();
    test_write_stall();
    test_simultaneous();
    test_alias();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
